// File: rtl/top_level_pkg.sv
// Shared constants and window-indexing helpers for the 3x3 binary convolution engine.
package top_level_pkg;

  localparam int COEF_W = 16;
  localparam int OUT_W  = 20;

  // Sharpen kernel, row-major, index 0 is top-left and 4 is the centre tap.
  localparam logic signed [COEF_W-1:0] KERNEL_DEFAULT [9] = '{
    16'sd0, -16'sd1, 16'sd0,
    -16'sd1, 16'sd5, -16'sd1,
    16'sd0, -16'sd1, 16'sd0
  };

  function automatic logic pix_in_win(input int r, input int c);
    return (r >= 0) && (r < 3) && (c >= 0) && (c < 3);
  endfunction

  // p(r,c) lives at X[8-(3r+c)]; only meaningful when pix_in_win(r,c) holds.
  function automatic logic [3:0] pix_idx(input int r, input int c);
    return 4'(8 - (3 * r + c));
  endfunction

endpackage

// File: rtl/top_level_conv_tap_sum.sv
// Combinational 3x3 correlation sum for one output position (R,C) of a binary window.
module conv_tap_sum
  import top_level_pkg::*;
#(
  parameter int R  = 0,
  parameter int C  = 0,
  parameter int CW = COEF_W,
  parameter int OW = OUT_W
) (
  input  logic [8:0]           win,
  input  logic signed [CW-1:0] kernel [9],
  output logic signed [OW-1:0] sum
);

  logic signed [OW-1:0] acc;
  logic signed [CW-1:0] kt;

  // Each pixel simply gates its coefficient; out-of-window neighbours add nothing.
  always_comb begin
    acc = '0;
    kt  = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        kt = kernel[4'((dr + 1) * 3 + (dc + 1))];
        if (pix_in_win(R + dr, C + dc) && win[pix_idx(R + dr, C + dc)]) begin
          acc = acc + {{(OW - CW){kt[CW-1]}}, kt};
        end
      end
    end
  end

  assign sum = acc;

endmodule

// File: rtl/top_level.sv
// Registered 3x3 binary-image convolution: nine zero-padded "same" sums, one-cycle latency.
module top_level
  import top_level_pkg::KERNEL_DEFAULT;
#(
  parameter int COEF_W = top_level_pkg::COEF_W,
  parameter int OUT_W  = top_level_pkg::OUT_W,
  parameter logic signed [COEF_W-1:0] K0 = COEF_W'(KERNEL_DEFAULT[0]),
  parameter logic signed [COEF_W-1:0] K1 = COEF_W'(KERNEL_DEFAULT[1]),
  parameter logic signed [COEF_W-1:0] K2 = COEF_W'(KERNEL_DEFAULT[2]),
  parameter logic signed [COEF_W-1:0] K3 = COEF_W'(KERNEL_DEFAULT[3]),
  parameter logic signed [COEF_W-1:0] K4 = COEF_W'(KERNEL_DEFAULT[4]),
  parameter logic signed [COEF_W-1:0] K5 = COEF_W'(KERNEL_DEFAULT[5]),
  parameter logic signed [COEF_W-1:0] K6 = COEF_W'(KERNEL_DEFAULT[6]),
  parameter logic signed [COEF_W-1:0] K7 = COEF_W'(KERNEL_DEFAULT[7]),
  parameter logic signed [COEF_W-1:0] K8 = COEF_W'(KERNEL_DEFAULT[8])
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [8:0]              X,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] output_0,
  output logic signed [OUT_W-1:0] output_1,
  output logic signed [OUT_W-1:0] output_2,
  output logic signed [OUT_W-1:0] output_3,
  output logic signed [OUT_W-1:0] output_4,
  output logic signed [OUT_W-1:0] output_5,
  output logic signed [OUT_W-1:0] output_6,
  output logic signed [OUT_W-1:0] output_7,
  output logic signed [OUT_W-1:0] output_8
);

  logic signed [COEF_W-1:0] kern [9];
  logic signed [OUT_W-1:0]  sums [9];
  logic signed [OUT_W-1:0]  res  [9];

  assign kern[0] = K0;
  assign kern[1] = K1;
  assign kern[2] = K2;
  assign kern[3] = K3;
  assign kern[4] = K4;
  assign kern[5] = K5;
  assign kern[6] = K6;
  assign kern[7] = K7;
  assign kern[8] = K8;

  for (genvar i = 0; i < 9; i++) begin : g_tap
    conv_tap_sum #(
      .R (i / 3),
      .C (i % 3),
      .CW(COEF_W),
      .OW(OUT_W)
    ) u_tap (
      .win   (X),
      .kernel(kern),
      .sum   (sums[i])
    );
  end

  // Results hold while idle; only out_valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      for (int i = 0; i < 9; i++) res[i] <= '0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      for (int i = 0; i < 9; i++) res[i] <= sums[i];
    end else begin
      out_valid <= 1'b0;
    end
  end

  assign output_0 = res[0];
  assign output_1 = res[1];
  assign output_2 = res[2];
  assign output_3 = res[3];
  assign output_4 = res[4];
  assign output_5 = res[5];
  assign output_6 = res[6];
  assign output_7 = res[7];
  assign output_8 = res[8];

endmodule

// File: tb/tb_top_level.sv
// Bench for top_level: scatter-form reference model checked every cycle plus literal spot checks.
module tb_top_level;

  typedef int arr9_t [9];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [8:0] X = '0;

  logic               va, vb;
  logic signed [19:0] oa [9];
  logic signed [19:0] ob [9];

  top_level dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .X(X), .out_valid(va),
    .output_0(oa[0]), .output_1(oa[1]), .output_2(oa[2]),
    .output_3(oa[3]), .output_4(oa[4]), .output_5(oa[5]),
    .output_6(oa[6]), .output_7(oa[7]), .output_8(oa[8])
  );

  top_level #(
    .K0(16'sh8000), .K1(16'sh8000), .K2(16'sh8000),
    .K3(16'sh8000), .K4(16'sh8000), .K5(16'sh8000),
    .K6(16'sh8000), .K7(16'sh8000), .K8(16'sh8000)
  ) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .X(X), .out_valid(vb),
    .output_0(ob[0]), .output_1(ob[1]), .output_2(ob[2]),
    .output_3(ob[3]), .output_4(ob[4]), .output_5(ob[5]),
    .output_6(ob[6]), .output_7(ob[7]), .output_8(ob[8])
  );

  int n_vec = 0;
  int n_err = 0;
  bit started = 1'b0;

  arr9_t ka = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
  arr9_t kb = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};

  // Scatter form: every set pixel deposits its coefficient on each output it neighbours.
  function automatic arr9_t model(input logic [8:0] x, input arr9_t k);
    arr9_t o;
    for (int i = 0; i < 9; i++) o[i] = 0;
    for (int pr = 0; pr < 3; pr++)
      for (int pc = 0; pc < 3; pc++)
        if (x[4'(8 - (3 * pr + pc))])
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              if ((pr - r) >= -1 && (pr - r) <= 1 && (pc - c) >= -1 && (pc - c) <= 1)
                o[3 * r + c] += k[(pr - r + 1) * 3 + (pc - c + 1)];
    return o;
  endfunction

  bit    ev = 1'b0;
  arr9_t ea = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
  arr9_t eb = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

  always @(posedge clk) begin
    if (rst) begin
      ev <= 1'b0;
      ea <= '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      eb <= '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    end else if (in_valid) begin
      ev <= 1'b1;
      ea <= model(X, ka);
      eb <= model(X, kb);
    end else begin
      ev <= 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("model va", int'(va), int'(ev));
      chk("model vb", int'(vb), int'(ev));
      for (int i = 0; i < 9; i++) begin
        chk($sformatf("model a.output_%0d", i), int'(oa[i]), ea[i]);
        chk($sformatf("model b.output_%0d", i), int'(ob[i]), eb[i]);
      end
    end
  end

  task automatic apply(input logic [8:0] x, input logic v);
    @(negedge clk);
    X = x;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  logic [8:0] extra [6] = '{9'h0F0, 9'h111, 9'h1AB, 9'h055, 9'h100, 9'h01E};

  initial begin
    rst = 1'b1;
    @(posedge clk);
    started = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("t1 valid", int'(va), 0);
    chk("t1 out0", int'(oa[0]), 0);
    chk("t1 out4", int'(oa[4]), 0);

    apply(9'b101010101, 1'b1);
    chk("t2 valid", int'(va), 1);
    chk("t2 out0", int'(oa[0]), 5);
    chk("t2 out1", int'(oa[1]), -3);
    chk("t2 out4", int'(oa[4]), 5);
    chk("t2 out7", int'(oa[7]), -3);
    apply(9'h000, 1'b0);
    chk("t2 hold valid", int'(va), 0);
    chk("t2 hold out0", int'(oa[0]), 5);
    chk("t2 hold out1", int'(oa[1]), -3);

    apply(9'b001010100, 1'b1);
    chk("t3 out0", int'(oa[0]), 0);
    chk("t3 out1", int'(oa[1]), -2);
    chk("t3 out2", int'(oa[2]), 5);
    chk("t3 out4", int'(oa[4]), 5);
    chk("t3 out8", int'(oa[8]), 0);

    apply(9'h000, 1'b1);
    chk("t4a valid", int'(va), 1);
    chk("t4a out4", int'(oa[4]), 0);
    apply(9'h1FF, 1'b1);
    chk("t4b valid", int'(va), 1);
    chk("t4b out0", int'(oa[0]), 3);
    chk("t4b out1", int'(oa[1]), 2);
    chk("t4b out4", int'(oa[4]), 1);
    chk("t4b out8", int'(oa[8]), 3);
    chk("t5 centre", int'(ob[4]), -294912);
    chk("t5 corner", int'(ob[0]), -131072);
    chk("t5 edge", int'(ob[5]), -196608);

    for (int i = 0; i < 6; i++) apply(extra[i], logic'(i % 3 != 2));

    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    X = 9'h1FF;
    @(posedge clk);
    #1;
    chk("t6 valid", int'(va), 0);
    chk("t6 out4", int'(oa[4]), 0);
    chk("t6 b out4", int'(ob[4]), 0);
    @(negedge clk);
    rst = 1'b0;
    X = 9'h010;
    @(posedge clk);
    #1;
    chk("t6 recover valid", int'(va), 1);
    chk("t6 recover out4", int'(oa[4]), 5);
    chk("t6 recover out1", int'(oa[1]), -1);

    apply(9'h000, 1'b0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/top_level.md
Name: top_level

Overview:
- Registered 3x3 binary-image convolution engine.
- A 9-bit input word is a 3x3 window of 1-bit pixels. The block convolves it with a fixed, parameterised 3x3 signed kernel using zero padding and "same" output size.
- It produces nine signed 20-bit results, one per pixel position.
- Sits after a binarisation stage and feeds downstream edge/feature logic.

Parameters:
- COEF_W, 16, signed kernel coefficient width.
- OUT_W, 20, output width. Must be >= COEF_W+4 so that a 9-term sum cannot overflow.
- K0..K8, defaults 0,-1,0,-1,5,-1,0,-1,0 (sharpen kernel), signed COEF_W coefficients in row-major order. K0 is top-left, K4 is centre.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, X is sampled when high.
- X, input, 9, pixel window. X[8] is p(0,0) (top-left) and X[0] is p(2,2); p(r,c) = X[8-(3r+c)].
- out_valid, output, 1, high for one cycle per accepted input.
- output_0..output_8, output, OUT_W signed each, result for position i = 3r+c in row-major order.

Behaviour:
- Reset: while rst is high at a clk edge, out_valid and output_0..output_8 are set to 0. Reset overrides in_valid on the same edge.
- Arithmetic:
  - output(r,c) = sum over dr,dc in {-1,0,1} of K[(1+dr)*3+(1+dc)] * p(r+dr, c+dc).
  - Out-of-window neighbours count as 0 (zero padding).
  - The kernel is applied as correlation, not flipped. The default kernel is symmetric.
- Each pixel is a 0/1 gate on its coefficient, so no multipliers are needed. A product is either sign-extended K or 0.
- All terms are sign-extended to OUT_W before summation. No saturation is needed, because the worst case 9*(-2^15) = -294912 fits in 20 bits.
- Latency: one cycle.
  - If in_valid=1 at edge N (and rst=0), the outputs hold the result for that X after edge N, and out_valid=1 after edge N.
  - If in_valid=0 at an edge, out_valid goes to 0 and the outputs hold their previous values.
- Back-to-back valid inputs: a new result every cycle (full throughput). There is no backpressure.
- Reset mid-stream: any result pending at that edge is discarded. The first valid input after rst deasserts gives out_valid one cycle later.
- Outputs change only on clk edges. There are no combinational paths from X to the outputs.

Decomposition:
- Shared package:
  - constants COEF_W and OUT_W;
  - default kernel constant array KERNEL_DEFAULT[9];
  - a function returning the pixel index for (r,c), used for bounds and zero padding.
- One natural sub-module, conv_tap_sum. It is combinational: it takes the 9-bit window, a position (r,c) and the kernel, and returns the OUT_W sum. top_level instantiates it 9 times (generate loop) and registers the results.

Test Plan:
1. rst=1 for 2 cycles, then 0 with in_valid=0 -> out_valid=0 and all outputs 0.
2. X=9'b101010101, in_valid=1 for one cycle:
   - next cycle outputs 0..8 = 5,-3,5,-3,5,-3,5,-3,5 and out_valid=1;
   - the cycle after, out_valid=0 with values held.
3. X=9'b001010100 -> outputs 0,-2,5,-2,5,-2,5,-2,0.
4. Back-to-back X=9'h000 then 9'h1FF on consecutive cycles:
   - first result all 0;
   - second result 3,2,3,2,1,2,3,2,3;
   - out_valid high on both cycles.
5. Parameter override with all K = -32768 and X=9'h1FF:
   - output_4 = -294912;
   - corners = -131072;
   - edges = -196608.
6. Assert rst in the same cycle as in_valid=1 with X=9'h1FF -> next cycle out_valid=0 and all outputs 0.
